// File: rtl/inst_rom_pkg.sv
// Shared widths, constants, FSM state encoding and byte-packing helper for the
// instruction ROM.
package inst_rom_pkg;

  localparam int INST_W     = 32;
  localparam int ADDR_BUS_W = 32;
  localparam int BYTE_W     = 8;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Big-endian assembly: the three earlier bytes occupy the upper bits.
  function automatic logic [INST_W-1:0] pack_be(input logic [INST_W-BYTE_W-1:0] upper,
                                                input logic [BYTE_W-1:0] low);
    return {upper, low};
  endfunction

endpackage

// File: rtl/inst_rom_if.sv
// Fetch and loader bus between the core/loader (master) and the ROM (slave).
interface inst_rom_if
  import inst_rom_pkg::*;
#(
  parameter int ADDR_W = 10
);

  logic                  ce_i;
  logic [ADDR_BUS_W-1:0] addr_i;
  logic [INST_W-1:0]     inst_o;

  logic                  load_start_i;
  logic                  load_valid_i;
  logic [BYTE_W-1:0]     load_byte_i;
  logic                  load_end_i;
  logic                  load_ready_o;
  logic                  load_done_o;
  logic                  load_err_o;
  logic                  cpu_rst_o;
  logic [ADDR_W:0]       words_o;

  modport master (
    output ce_i, addr_i, load_start_i, load_valid_i, load_byte_i, load_end_i,
    input  inst_o, load_ready_o, load_done_o, load_err_o, cpu_rst_o, words_o
  );

  modport slave (
    input  ce_i, addr_i, load_start_i, load_valid_i, load_byte_i, load_end_i,
    output inst_o, load_ready_o, load_done_o, load_err_o, cpu_rst_o, words_o
  );

endinterface

// File: rtl/inst_rom_mem.sv
// Single-port word array: synchronous write, asynchronous read on the same address.
module inst_rom_mem #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write port; contents are never cleared by reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/inst_rom.sv
// Run-time loadable instruction memory: byte loader FSM, big-endian word
// assembly, length tracking, core reset control and combinational fetch decode.
module inst_rom
  import inst_rom_pkg::*;
#(
  parameter int              ADDR_W   = 10,
  parameter logic [INST_W-1:0] NOP_WORD = NOP_INST
) (
  input logic       clk,
  input logic       rst,
  inst_rom_if.slave bus
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_t                    state;
  logic [1:0]                byte_cnt;
  logic [INST_W-BYTE_W-1:0]  asm_q;
  logic [ADDR_W:0]           words;
  logic                      err;
  logic                      ready;
  logic                      done;
  logic                      cpu_rst;

  logic                      take;
  logic                      word_done;
  logic                      overflow;
  logic                      we;
  logic                      end_ok;
  logic [ADDR_W-1:0]         fetch_idx;
  logic                      fetch_hit;
  logic [ADDR_W-1:0]         mem_addr;
  logic [INST_W-1:0]         mem_rdata;
  logic                      unused_addr_bits;

  // A start pulse wins over any byte or end in the same cycle.
  assign take      = (state == ST_LOAD) && !bus.load_start_i && bus.load_valid_i;
  assign word_done = take && (byte_cnt == 2'd3);
  assign overflow  = word_done && (words == DEPTH);
  assign we        = word_done && !overflow;

  // End succeeds only on a word boundary (after any byte taken this cycle) and
  // with at least one word in the image, counting a word written this cycle.
  assign end_ok = (take ? (byte_cnt == 2'd3) : (byte_cnt == 2'd0)) &&
                  ((words != '0) || we);

  assign fetch_idx = bus.addr_i[ADDR_W+1:2];
  assign fetch_hit = bus.ce_i && (state == ST_RUN) &&
                     (bus.addr_i[ADDR_BUS_W-1:ADDR_W+2] == '0) &&
                     ({1'b0, fetch_idx} < words);

  // Writes only happen in LOAD and reads only matter in RUN, so one port serves both.
  assign mem_addr = we ? words[ADDR_W-1:0] : fetch_idx;

  assign unused_addr_bits = ^bus.addr_i[1:0];

  inst_rom_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (INST_W)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .addr  (mem_addr),
    .wdata (pack_be(asm_q, bus.load_byte_i)),
    .rdata (mem_rdata)
  );

  // Byte shift register for the partial word; data only, so no reset.
  always_ff @(posedge clk) begin
    if (take) asm_q <= {asm_q[INST_W-2*BYTE_W-1:0], bus.load_byte_i};
  end

  // Loader FSM with registered state decodes for ready/done/core reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      byte_cnt <= 2'd0;
      words    <= '0;
      err      <= 1'b0;
      ready    <= 1'b0;
      done     <= 1'b0;
      cpu_rst  <= 1'b1;
    end else if (bus.load_start_i) begin
      state    <= ST_LOAD;
      byte_cnt <= 2'd0;
      words    <= '0;
      err      <= 1'b0;
      ready    <= 1'b1;
      done     <= 1'b0;
      cpu_rst  <= 1'b1;
    end else if (state == ST_LOAD) begin
      if (take) byte_cnt <= byte_cnt + 2'd1;
      if (we)   words    <= words + 1'b1;
      if (overflow) begin
        state   <= ST_IDLE;
        err     <= 1'b1;
        ready   <= 1'b0;
        done    <= 1'b0;
        cpu_rst <= 1'b1;
      end else if (bus.load_end_i) begin
        if (end_ok) begin
          state   <= ST_RUN;
          ready   <= 1'b0;
          done    <= 1'b1;
          cpu_rst <= 1'b0;
        end else begin
          state   <= ST_IDLE;
          err     <= 1'b1;
          ready   <= 1'b0;
          done    <= 1'b0;
          cpu_rst <= 1'b1;
        end
      end
    end
  end

  assign bus.inst_o       = fetch_hit ? mem_rdata : NOP_WORD;
  assign bus.load_ready_o = ready;
  assign bus.load_done_o  = done;
  assign bus.load_err_o   = err;
  assign bus.cpu_rst_o    = cpu_rst;
  assign bus.words_o      = words;

endmodule

// File: tb/tb_inst_rom.sv
// Scoreboard bench for inst_rom: two instances (1024-word and 4-word) share one
// stimulus stream; a byte-list reference model predicts every cycle's outputs.
module tb_inst_rom;

  localparam int AW_BIG   = 10;
  localparam int AW_SMALL = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b1;
  logic [31:0] addr = 32'h0;
  logic        start = 1'b0;
  logic        valid = 1'b0;
  logic [7:0]  ld_byte = 8'h0;
  logic        endp = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  inst_rom_if #(.ADDR_W(AW_BIG))   if_big ();
  inst_rom_if #(.ADDR_W(AW_SMALL)) if_small ();

  assign if_big.ce_i           = ce;
  assign if_big.addr_i         = addr;
  assign if_big.load_start_i   = start;
  assign if_big.load_valid_i   = valid;
  assign if_big.load_byte_i    = ld_byte;
  assign if_big.load_end_i     = endp;
  assign if_small.ce_i         = ce;
  assign if_small.addr_i       = addr;
  assign if_small.load_start_i = start;
  assign if_small.load_valid_i = valid;
  assign if_small.load_byte_i  = ld_byte;
  assign if_small.load_end_i   = endp;

  inst_rom #(.ADDR_W(AW_BIG)) dut_big (
    .clk (clk),
    .rst (rst),
    .bus (if_big)
  );

  inst_rom #(.ADDR_W(AW_SMALL)) dut_small (
    .clk (clk),
    .rst (rst),
    .bus (if_small)
  );

  // ---------------- reference model ----------------
  // m_st: 0 = no image, 1 = loading, 2 = image running
  int          m_aw    [2] = '{AW_BIG, AW_SMALL};
  int          m_st    [2];
  int          m_words [2];
  logic        m_err   [2];
  int          m_pend_n[2];
  logic [31:0] m_pend  [2];
  logic [31:0] m_mem   [2][1024];

  typedef struct {
    int          d;
    logic [31:0] inst;
    logic        ready;
    logic        done;
    logic        err;
    logic        crst;
    int          words;
  } exp_t;

  exp_t sb[$];

  task automatic model_reset(input int d);
    m_st[d]     = 0;
    m_words[d]  = 0;
    m_err[d]    = 1'b0;
    m_pend_n[d] = 0;
    m_pend[d]   = 32'h0;
  endtask

  // Apply one clock edge with the inputs that were being driven.
  task automatic model_step(input int d);
    int depth;
    depth = 1 << m_aw[d];
    if (rst) begin
      model_reset(d);
      return;
    end
    if (start) begin
      m_st[d]     = 1;
      m_words[d]  = 0;
      m_err[d]    = 1'b0;
      m_pend_n[d] = 0;
      m_pend[d]   = 32'h0;
      return;
    end
    if (m_st[d] != 1) return;
    if (valid) begin
      m_pend[d]   = m_pend[d] * 256 + 32'(ld_byte);
      m_pend_n[d] = m_pend_n[d] + 1;
      if (m_pend_n[d] == 4) begin
        m_pend_n[d] = 0;
        if (m_words[d] == depth) begin
          m_err[d] = 1'b1;
          m_st[d]  = 0;
          return;
        end
        m_mem[d][m_words[d]] = m_pend[d];
        m_words[d] = m_words[d] + 1;
        m_pend[d]  = 32'h0;
      end
    end
    if (endp) begin
      if (m_pend_n[d] == 0 && m_words[d] > 0) m_st[d] = 2;
      else begin
        m_err[d] = 1'b1;
        m_st[d]  = 0;
      end
    end
  endtask

  task automatic push_expect(input int d);
    exp_t e;
    int   idx;
    longint upper;
    idx   = int'((addr >> 2) & ((32'd1 << m_aw[d]) - 1));
    upper = longint'(addr) >> (m_aw[d] + 2);
    e.d     = d;
    e.inst  = (ce && m_st[d] == 2 && upper == 0 && idx < m_words[d]) ? m_mem[d][idx] : 32'h0;
    e.ready = (m_st[d] == 1);
    e.done  = (m_st[d] == 2);
    e.err   = m_err[d];
    e.crst  = (m_st[d] != 2);
    e.words = m_words[d];
    sb.push_back(e);
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t: got %h expected %h", name, d, $time, act, exp);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.d == 0) begin
        chk("inst",    0, if_big.inst_o, e.inst);
        chk("ready",   0, 32'(if_big.load_ready_o), 32'(e.ready));
        chk("done",    0, 32'(if_big.load_done_o), 32'(e.done));
        chk("err",     0, 32'(if_big.load_err_o), 32'(e.err));
        chk("cpu_rst", 0, 32'(if_big.cpu_rst_o), 32'(e.crst));
        chk("words",   0, 32'(if_big.words_o), 32'(e.words));
      end else begin
        chk("inst",    1, if_small.inst_o, e.inst);
        chk("ready",   1, 32'(if_small.load_ready_o), 32'(e.ready));
        chk("done",    1, 32'(if_small.load_done_o), 32'(e.done));
        chk("err",     1, 32'(if_small.load_err_o), 32'(e.err));
        chk("cpu_rst", 1, 32'(if_small.cpu_rst_o), 32'(e.crst));
        chk("words",   1, 32'(if_small.words_o), 32'(e.words));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle(input logic s, input logic v, input logic [7:0] b, input logic e,
                       input logic c, input logic [31:0] a);
    @(posedge clk);
    #1;
    model_step(0);
    model_step(1);
    start = s; valid = v; ld_byte = b; endp = e; ce = c; addr = a;
    push_expect(0);
    push_expect(1);
  endtask

  task automatic set_rst(input logic r);
    @(posedge clk);
    #1;
    model_step(0);
    model_step(1);
    rst = r;
    if (r) begin
      model_reset(0);
      model_reset(1);
    end
    start = 1'b0; valid = 1'b0; endp = 1'b0;
    push_expect(0);
    push_expect(1);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom % 4)
      0: rand_addr = {27'h0, 5'($urandom)};
      1: rand_addr = 32'($urandom_range(0, 8191));
      2: rand_addr = $urandom;
      default: rand_addr = {4'($urandom), 28'h0} | 32'($urandom_range(0, 31));
    endcase
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic e);
    cycle(1'b0, 1'b1, b, e, 1'b1, rand_addr());
  endtask

  task automatic fetch(input logic [31:0] a);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, a);
  endtask

  logic [7:0] img [8] = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h34, 8'h02, 8'h00, 8'h07};

  initial begin
    int nw;
    int extra;
    int nbytes;
    logic together;

    model_reset(0);
    model_reset(1);
    push_expect(0);
    push_expect(1);

    // reset state with a fetch at address 0
    fetch(32'h0);
    fetch(32'h0);
    set_rst(1'b0);
    fetch(32'h0);

    // two-word image, then directed fetches
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 8; i++) send_byte(img[i], 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h0);
    fetch(32'h0);
    fetch(32'h4);
    fetch(32'h8);
    fetch(32'h5);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
    fetch(32'h1000_0000);

    // partial-word image is rejected
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h0);
    fetch(32'h0);
    fetch(32'h0);

    // empty image is rejected
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 32'h0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h0);
    fetch(32'h0);

    // fourth byte and end together
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 32'h0);
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    send_byte(8'hBE, 1'b0);
    send_byte(8'hEF, 1'b1);
    fetch(32'h0);
    fetch(32'h3);

    // start with a byte in RUN: byte dropped, ROM back to loading
    cycle(1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 32'h0);
    fetch(32'h0);
    fetch(32'h0);

    // five words: the 4-word instance overflows on the 20th byte
    for (int i = 0; i < 20; i++) send_byte(8'(i * 7 + 3), 1'b0);
    fetch(32'h0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h10);
    fetch(32'h10);
    fetch(32'hC);
    for (int i = 0; i < 4; i++)
      chk("ovf_mem", 1, dut_small.u_mem.mem[i], m_mem[1][i]);

    // reset in the middle of a load
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0);
    set_rst(1'b1);
    fetch(32'h0);
    set_rst(1'b0);
    cycle(1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 32'h0);
    fetch(32'h0);

    // randomized loads, fetches and stray loader activity
    for (int n = 0; n < 80; n++) begin
      nw       = $urandom_range(0, 6);
      extra    = ($urandom % 5 == 0) ? $urandom_range(1, 3) : 0;
      nbytes   = nw * 4 + extra;
      together = 1'b0;
      cycle(1'b1, 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), rand_addr());
      for (int i = 0; i < nbytes; i++) begin
        while ($urandom % 4 == 0)
          cycle(1'b0, 1'b0, 8'($urandom), 1'b0, 1'($urandom), rand_addr());
        together = (i == nbytes - 1) && ($urandom % 2 == 1);
        send_byte(8'($urandom), together);
      end
      if (!together && ($urandom % 8 != 0))
        cycle(1'b0, 1'($urandom), 8'($urandom), 1'b1, 1'($urandom), rand_addr());
      if ($urandom % 16 == 0) begin
        set_rst(1'b1);
        set_rst(1'b0);
      end
      for (int k = 0; k < int'($urandom_range(4, 20)); k++)
        cycle(1'b0, 1'($urandom % 3 == 0), 8'($urandom), 1'($urandom % 8 == 0),
              1'($urandom % 8 != 0), rand_addr());
    end

    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
